// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_pkg
// Description : Shared types and constants for the UART byte sequencers.
//               Holds the launch FSM state encoding and the busy-wait timeout,
//               which the rx-side sequencer also uses.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

    localparam int DATA_W             = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    // Cycles the sequencer waits in S_WAIT_BUSY for the transmitter to raise
    // busy before it gives up on the launched byte.
    localparam logic [1:0] WAIT_BUSY_TIMEOUT = 2'd3;
    localparam logic [1:0] WAIT_BUSY_LAST    = WAIT_BUSY_TIMEOUT - 2'd1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_DRAIN     = 2'd3
    } seq_state_e;

endpackage : uart_tx_fifo_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Producer-side write port and transmitter-side launch port of
//               the UART tx FIFO. The slave modport is the FIFO itself; the
//               master modport is the surrounding logic (producers plus the
//               transmitter's busy flag).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);
    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic [DATA_W-1:0]   tx_byte;
    logic                tx_start;
    logic                tx_busy;

    modport master (
        output wr_data, wr_en, tx_busy,
        input  full, empty, count, overflow, tx_byte, tx_start
    );

    modport slave (
        input  wr_data, wr_en, tx_busy,
        output full, empty, count, overflow, tx_byte, tx_start
    );

endinterface : uart_tx_fifo_if
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : Simple dual-port byte storage for the UART FIFOs. Registered
//               write, asynchronous read so the sequencer can capture the head
//               byte in the same cycle it pops it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  wire logic                  clk,
    input  wire logic                  we_i,
    input  wire logic [DEPTH_LOG2-1:0] waddr_i,
    input  wire logic [DATA_W-1:0]     wdata_i,
    input  wire logic [DEPTH_LOG2-1:0] raddr_i,
    output      logic [DATA_W-1:0]     rdata_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO plus launch sequencer in front of the UART
//               transmitter. Producers push at clock rate; the sequencer pops
//               one byte at a time, pulses tx_start and paces itself on the
//               transmitter's busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input wire logic      clk,
    input wire logic      reset,
    uart_tx_fifo_if.slave fifo_if
);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_W-1:0]     tx_byte_q, tx_byte_d;
    logic                  tx_start_q, tx_start_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    seq_state_e            state_q, state_d;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_W-1:0]     rd_data;

    // Full/empty come from the registered count, so a write while full is
    // dropped even when the sequencer pops in the same cycle.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign push  = fifo_if.wr_en && !full;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (fifo_if.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // State register for pointers, count, sticky overflow and the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_byte_q  <= '0;
            tx_start_q <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_DRAIN;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            wait_cnt_q <= wait_cnt_d;
            state_q    <= state_d;
        end
    end

    // Pointer and occupancy update; a simultaneous push and pop leaves count alone.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (fifo_if.wr_en && full) begin
            overflow_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Launch sequencer: pop, pulse start, wait for busy (bounded), then wait
    // for the frame to finish. A launched byte is never re-sent.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tx_byte_d  = tx_byte_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_byte_d  = rd_data;
                    tx_start_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (fifo_if.tx_busy || (wait_cnt_q == WAIT_BUSY_LAST)) begin
                    state_d = S_DRAIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (!fifo_if.tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_DRAIN;
        endcase
    end

    assign fifo_if.full     = full;
    assign fifo_if.empty    = empty;
    assign fifo_if.count    = count_q;
    assign fifo_if.overflow = overflow_q;
    assign fifo_if.tx_byte  = tx_byte_q;
    assign fifo_if.tx_start = tx_start_q;

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo with a behavioural
//               transmitter model (busy rises one cycle after an accepted
//               start and stays high busy_len cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();
    uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (.clk(clk), .reset(reset), .fifo_if(bus));

    int checks   = 0;
    int failures = 0;

    // Transmitter model state
    bit         hold_busy    = 1'b0;
    bit         ignore_start = 1'b0;
    bit         chk_byte     = 1'b1;
    int         busy_len     = 4;
    int         rem          = 0;
    logic [7:0] sent[$];
    logic [7:0] cur_byte     = 8'h00;
    bit         prev_start   = 1'b0;
    int         dbl_cnt      = 0;
    int         sbusy_cnt    = 0;
    int         glitch_cnt   = 0;

    assign bus.tx_busy = hold_busy | (rem != 0);

    // Transmitter: accepts start only when idle; records each accepted byte.
    always @(posedge clk) begin
        prev_start <= bus.tx_start;
        if (bus.tx_start && prev_start) dbl_cnt <= dbl_cnt + 1;
        if (bus.tx_start && bus.tx_busy) sbusy_cnt <= sbusy_cnt + 1;
        if (chk_byte && rem != 0 && bus.tx_byte !== cur_byte) glitch_cnt <= glitch_cnt + 1;
        if (bus.tx_start && !bus.tx_busy && !ignore_start) begin
            rem      <= busy_len;
            cur_byte <= bus.tx_byte;
            sent.push_back(bus.tx_byte);
        end else if (rem != 0) begin
            rem <= rem - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit hold);
        hold_busy  = hold;
        bus.wr_en  = 1'b0;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
    endtask

    task automatic write1(input logic [7:0] d);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Waits until n bytes were accepted and everything stays quiet for 8 cycles.
    task automatic wait_drain(input int n, output bit to);
        int quiet;
        quiet = 0;
        to    = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (sent.size() >= n && !bus.tx_busy && bus.empty) quiet++;
            else quiet = 0;
            if (quiet >= 8) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", bus.tx_start); end
        checks++; if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h exp=00", bus.tx_byte); end
    endtask

    task automatic test_single();
        bit to;
        tick(); tick();
        sent.delete();
        busy_len = 6;
        write1(8'hA5);
        checks++; if (bus.count !== 5'd1) begin failures++; $display("FAIL single_count_after_write got=%0d exp=1", bus.count); end
        tick();
        checks++; if (bus.tx_start !== 1'b1) begin failures++; $display("FAIL single_start_latency got=%b exp=1", bus.tx_start); end
        checks++; if (bus.tx_byte !== 8'hA5) begin failures++; $display("FAIL single_tx_byte got=%h exp=a5", bus.tx_byte); end
        checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL single_count_after_pop got=%0d/%b exp=0/1", bus.count, bus.empty); end
        tick();
        checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL single_start_width got=%b exp=0", bus.tx_start); end
        wait_drain(1, to);
        checks++; if (to) begin failures++; $display("FAIL single_drain_timeout got=%0d bytes exp=1", sent.size()); end
        checks++; if (sent.size() != 1 || sent[0] !== 8'hA5) begin failures++; $display("FAIL single_stream got_size=%0d exp_size=1", sent.size()); end
        checks++; if (bus.tx_byte !== 8'hA5) begin failures++; $display("FAIL single_byte_held got=%h exp=a5", bus.tx_byte); end
    endtask

    task automatic test_burst();
        bit to;
        int starts;
        int bad;
        do_reset(1'b1);
        sent.delete();
        busy_len = 4;
        for (int i = 0; i < DEPTH; i++) write1(8'(i));
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL burst_full got=%b exp=1", bus.full); end
        checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL burst_count got=%0d exp=16", bus.count); end
        hold_busy = 1'b0;
        starts = 0;
        bad    = 0;
        for (int c = 0; c < 2000 && starts < DEPTH; c++) begin
            tick();
            if (bus.tx_start) begin
                starts++;
                if (bus.count !== 5'(DEPTH - starts)) bad++;
            end
        end
        checks++; if (bad != 0 || starts != DEPTH) begin failures++; $display("FAIL burst_count_decrement bad=%0d starts=%0d exp_starts=16", bad, starts); end
        wait_drain(DEPTH, to);
        checks++; if (to) begin failures++; $display("FAIL burst_drain_timeout got=%0d exp=16", sent.size()); end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (i >= sent.size() || sent[i] !== 8'(i)) bad++;
        checks++; if (bad != 0 || sent.size() != DEPTH) begin failures++; $display("FAIL burst_stream wrong=%0d size=%0d exp_size=16", bad, sent.size()); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL burst_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_overflow();
        bit to;
        int bad;
        logic [7:0] exp_q[$];
        do_reset(1'b1);
        sent.delete();
        busy_len = 3;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'($urandom));
            write1(exp_q[i]);
        end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_extra got=%b exp=0", bus.overflow); end
        write1(8'($urandom));
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin failures++; $display("FAIL ovf_full_count got=%b/%0d exp=1/16", bus.full, bus.count); end
        hold_busy = 1'b0;
        wait_drain(DEPTH, to);
        checks++; if (to) begin failures++; $display("FAIL ovf_drain_timeout got=%0d exp=16", sent.size()); end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (i >= sent.size() || sent[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0 || sent.size() != DEPTH) begin failures++; $display("FAIL ovf_stream wrong=%0d size=%0d exp_size=16", bad, sent.size()); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_timeout();
        bit to;
        int gap;
        logic [7:0] x, y;
        do_reset(1'b0);
        tick(); tick();
        sent.delete();
        busy_len = 5;
        x = 8'($urandom);
        y = 8'($urandom);
        ignore_start = 1'b1;
        write1(x);
        write1(y);
        checks++; if (bus.count !== 5'd1) begin failures++; $display("FAIL pop_write_count1 got=%0d exp=1", bus.count); end
        checks++; if (bus.tx_start !== 1'b1 || bus.tx_byte !== x) begin failures++; $display("FAIL timeout_first_start got=%b/%h exp=1/%h", bus.tx_start, bus.tx_byte, x); end
        tick();
        ignore_start = 1'b0;
        // launch (1) + busy wait timeout (3) + drain (1) + idle pop (1)
        gap = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            gap++;
            if (bus.tx_start) break;
        end
        checks++; if (gap != 6) begin failures++; $display("FAIL timeout_restart_gap got=%0d exp=6", gap); end
        wait_drain(1, to);
        checks++; if (to) begin failures++; $display("FAIL timeout_drain_timeout got=%0d exp=1", sent.size()); end
        checks++; if (sent.size() != 1 || sent[0] !== y) begin failures++; $display("FAIL timeout_no_retry size=%0d exp_size=1 exp_byte=%h", sent.size(), y); end
    endtask

    task automatic test_reset_midframe();
        bit to;
        bit viol;
        bit busy_stuck;
        logic [7:0] d[6];
        do_reset(1'b0);
        tick(); tick();
        sent.delete();
        busy_len = 30;
        for (int i = 0; i < 6; i++) begin
            d[i] = 8'($urandom);
            write1(d[i]);
        end
        tick();
        checks++; if (bus.count !== 5'd5) begin failures++; $display("FAIL midframe_queued got=%0d exp=5", bus.count); end
        chk_byte = 1'b0;
        do_reset(1'b0);
        checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL midframe_reset_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
        viol       = 1'b0;
        busy_stuck = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (!bus.tx_busy) begin
                busy_stuck = 1'b0;
                break;
            end
            if (bus.tx_start) viol = 1'b1;
            tick();
        end
        checks++; if (viol || busy_stuck) begin failures++; $display("FAIL midframe_start_while_busy got=%b stuck=%b exp=0", viol, busy_stuck); end
        chk_byte = 1'b1;
        write1(8'h3C);
        wait_drain(2, to);
        checks++; if (to) begin failures++; $display("FAIL midframe_drain_timeout got=%0d exp=2", sent.size()); end
        checks++; if (sent.size() != 2 || sent[0] !== d[0] || sent[1] !== 8'h3C) begin failures++; $display("FAIL midframe_stream size=%0d exp=2 last=%h exp_last=3c", sent.size(), sent.size() > 0 ? sent[sent.size()-1] : 8'hxx); end
    endtask

    task automatic test_full_pop();
        bit to;
        int bad;
        logic [7:0] exp_q[$];
        do_reset(1'b1);
        sent.delete();
        busy_len = 2;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'($urandom));
            write1(exp_q[i]);
        end
        hold_busy = 1'b0;
        tick();
        checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL fullpop_pre_count got=%0d exp=16", bus.count); end
        bus.wr_data = 8'($urandom);
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        checks++; if (bus.count !== 5'd15) begin failures++; $display("FAIL fullpop_count got=%0d exp=15", bus.count); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fullpop_overflow got=%b exp=1", bus.overflow); end
        wait_drain(DEPTH, to);
        checks++; if (to) begin failures++; $display("FAIL fullpop_drain_timeout got=%0d exp=16", sent.size()); end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (i >= sent.size() || sent[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0 || sent.size() != DEPTH) begin failures++; $display("FAIL fullpop_stream wrong=%0d size=%0d exp_size=16", bad, sent.size()); end
    endtask

    task automatic test_random();
        bit to;
        int bad;
        int n;
        logic [7:0] exp_q[$];
        do_reset(1'b0);
        for (int r = 0; r < 6; r++) begin
            sent.delete();
            exp_q.delete();
            busy_len = $urandom_range(1, 10);
            n        = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(8'($urandom));
                write1(exp_q[i]);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_drain(n, to);
            bad = 0;
            for (int i = 0; i < n; i++) if (i >= sent.size() || sent[i] !== exp_q[i]) bad++;
            checks++; if (to || bad != 0 || sent.size() != n) begin failures++; $display("FAIL random_stream round=%0d wrong=%0d size=%0d exp_size=%0d", r, bad, sent.size(), n); end
        end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL random_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_protocol();
        checks++; if (dbl_cnt != 0) begin failures++; $display("FAIL start_pulse_width long_pulses=%0d exp=0", dbl_cnt); end
        checks++; if (sbusy_cnt != 0) begin failures++; $display("FAIL start_while_busy got=%0d exp=0", sbusy_cnt); end
        checks++; if (glitch_cnt != 0) begin failures++; $display("FAIL tx_byte_stable changes=%0d exp=0", glitch_cnt); end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        tick();
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_full_pop();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog sim_time=%0t exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_fifo
`default_nettype wire
